// File: rtl/axi4_to_lite_bridge.sv
// AXI4 (burst) to AXI-lite bridge for the core MMIO port.
// Independent write and read engines, each converts one AXI4 burst into
// LEN+1 single-beat AXI-lite transactions. All outputs come from registers
// or from a decode of the registered state.
module axi4_to_lite_bridge (
    input  logic        CLK,
    input  logic        RST,
    // upstream AXI4 write address
    input  logic [3:0]  S_AWID,
    input  logic [30:0] S_AWADDR,
    input  logic [7:0]  S_AWLEN,
    input  logic [2:0]  S_AWSIZE,
    input  logic [1:0]  S_AWBURST,
    input  logic        S_AWVALID,
    output logic        S_AWREADY,
    // upstream AXI4 write data
    input  logic [63:0] S_WDATA,
    input  logic [7:0]  S_WSTRB,
    input  logic        S_WLAST,
    input  logic        S_WVALID,
    output logic        S_WREADY,
    // upstream AXI4 write response
    output logic [3:0]  S_BID,
    output logic [1:0]  S_BRESP,
    output logic        S_BVALID,
    input  logic        S_BREADY,
    // upstream AXI4 read address
    input  logic [3:0]  S_ARID,
    input  logic [30:0] S_ARADDR,
    input  logic [7:0]  S_ARLEN,
    input  logic [2:0]  S_ARSIZE,
    input  logic [1:0]  S_ARBURST,
    input  logic        S_ARVALID,
    output logic        S_ARREADY,
    // upstream AXI4 read data
    output logic [3:0]  S_RID,
    output logic [63:0] S_RDATA,
    output logic [1:0]  S_RRESP,
    output logic        S_RLAST,
    output logic        S_RVALID,
    input  logic        S_RREADY,
    // downstream AXI-lite
    output logic [30:0] M_AWADDR,
    output logic        M_AWVALID,
    input  logic        M_AWREADY,
    output logic [63:0] M_WDATA,
    output logic [7:0]  M_WSTRB,
    output logic        M_WVALID,
    input  logic        M_WREADY,
    input  logic [1:0]  M_BRESP,
    input  logic        M_BVALID,
    output logic        M_BREADY,
    output logic [30:0] M_ARADDR,
    output logic        M_ARVALID,
    input  logic        M_ARREADY,
    input  logic [63:0] M_RDATA,
    input  logic [1:0]  M_RRESP,
    input  logic        M_RVALID,
    output logic        M_RREADY
);

    typedef enum logic [2:0] {W_IDLE, W_DATA, W_ISSUE, W_RESP, W_BRESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_DATA} r_state_t;

    // Address of the following beat for FIXED / INCR / WRAP (reserved acts as INCR).
    function automatic logic [30:0] next_addr(input logic [30:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [30:0] inc;
        logic [30:0] mask;
        inc  = 31'd1 << ((size > 3'd3) ? 3'd3 : size);
        mask = ((31'(len) + 31'd1) << size) - 31'd1;
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~mask) | ((addr + inc) & mask);
            default: next_addr = addr + inc;
        endcase
    endfunction

    // Responses are ordered by severity, so merging is a numeric maximum.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        resp_max = (a > b) ? a : b;
    endfunction

    w_state_t    w_state;
    logic [3:0]  w_id;
    logic [30:0] w_addr;
    logic [7:0]  w_len;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic [7:0]  w_beat;
    logic [1:0]  w_resp;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        aw_done;
    logic        wd_done;

    r_state_t    r_state;
    logic [3:0]  r_id;
    logic [30:0] r_addr;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [7:0]  r_beat;
    logic [63:0] r_data;
    logic [1:0]  r_resp;

    // Write engine: accept burst header, then one data beat -> one lite write per beat.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_beat  <= '0;
            w_resp  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            aw_done <= 1'b0;
            wd_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            case (w_state)
                W_IDLE: if (S_AWVALID) begin
                    w_id    <= S_AWID;
                    w_addr  <= S_AWADDR;
                    w_len   <= S_AWLEN;
                    w_size  <= S_AWSIZE;
                    w_burst <= S_AWBURST;
                    w_beat  <= '0;
                    w_resp  <= '0;
                    w_state <= W_DATA;
                end
                W_DATA: if (S_WVALID) begin
                    w_data  <= S_WDATA;
                    w_strb  <= S_WSTRB;
                    // A misplaced WLAST does not shorten the burst, it only taints the response.
                    if (S_WLAST != (w_beat == w_len))
                        w_resp <= resp_max(w_resp, 2'd2);
                    aw_done <= 1'b0;
                    wd_done <= 1'b0;
                    w_state <= W_ISSUE;
                end
                W_ISSUE: begin
                    if (M_AWREADY) aw_done <= 1'b1;
                    if (M_WREADY)  wd_done <= 1'b1;
                    if ((aw_done || M_AWREADY) && (wd_done || M_WREADY))
                        w_state <= W_RESP;
                end
                W_RESP: if (M_BVALID) begin
                    w_resp <= resp_max(w_resp, M_BRESP);
                    if (w_beat == w_len) begin
                        w_state <= W_BRESP;
                    end else begin
                        w_addr  <= next_addr(w_addr, w_len, w_size, w_burst);
                        w_beat  <= w_beat + 8'd1;
                        w_state <= W_DATA;
                    end
                end
                W_BRESP: if (S_BREADY) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read engine: one lite read per beat, each returned beat is forwarded before the next issue.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            r_data  <= '0;
            r_resp  <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (S_ARVALID) begin
                    r_id    <= S_ARID;
                    r_addr  <= S_ARADDR;
                    r_len   <= S_ARLEN;
                    r_size  <= S_ARSIZE;
                    r_burst <= S_ARBURST;
                    r_beat  <= '0;
                    r_state <= R_ISSUE;
                end
                R_ISSUE: if (M_ARREADY) r_state <= R_WAIT;
                R_WAIT: if (M_RVALID) begin
                    r_data  <= M_RDATA;
                    r_resp  <= M_RRESP;
                    r_state <= R_DATA;
                end
                R_DATA: if (S_RREADY) begin
                    if (r_beat == r_len) begin
                        r_state <= R_IDLE;
                    end else begin
                        r_addr  <= next_addr(r_addr, r_len, r_size, r_burst);
                        r_beat  <= r_beat + 8'd1;
                        r_state <= R_ISSUE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Handshake outputs are pure decodes of the registered state.
    assign S_AWREADY = (w_state == W_IDLE);
    assign S_WREADY  = (w_state == W_DATA);
    assign M_AWVALID = (w_state == W_ISSUE) && !aw_done;
    assign M_WVALID  = (w_state == W_ISSUE) && !wd_done;
    assign M_BREADY  = (w_state == W_RESP);
    assign S_BVALID  = (w_state == W_BRESP);
    assign S_BID     = w_id;
    assign S_BRESP   = w_resp;
    assign M_AWADDR  = w_addr;
    assign M_WDATA   = w_data;
    assign M_WSTRB   = w_strb;

    assign S_ARREADY = (r_state == R_IDLE);
    assign M_ARVALID = (r_state == R_ISSUE);
    assign M_RREADY  = (r_state == R_WAIT);
    assign S_RVALID  = (r_state == R_DATA);
    assign S_RLAST   = (r_state == R_DATA) && (r_beat == r_len);
    assign S_RID     = r_id;
    assign S_RDATA   = r_data;
    assign S_RRESP   = r_resp;
    assign M_ARADDR  = r_addr;

endmodule

// File: tb/tb_axi4_to_lite_bridge.sv
// Self-checking bench for axi4_to_lite_bridge: a randomised downstream slave,
// an upstream master driving bursts, and a queue-based reference model.
module tb_axi4_to_lite_bridge;

    logic        CLK, RST;
    logic [3:0]  S_AWID;   logic [30:0] S_AWADDR; logic [7:0] S_AWLEN;
    logic [2:0]  S_AWSIZE; logic [1:0]  S_AWBURST; logic S_AWVALID, S_AWREADY;
    logic [63:0] S_WDATA;  logic [7:0]  S_WSTRB;  logic S_WLAST, S_WVALID, S_WREADY;
    logic [3:0]  S_BID;    logic [1:0]  S_BRESP;  logic S_BVALID, S_BREADY;
    logic [3:0]  S_ARID;   logic [30:0] S_ARADDR; logic [7:0] S_ARLEN;
    logic [2:0]  S_ARSIZE; logic [1:0]  S_ARBURST; logic S_ARVALID, S_ARREADY;
    logic [3:0]  S_RID;    logic [63:0] S_RDATA;  logic [1:0] S_RRESP;
    logic        S_RLAST, S_RVALID, S_RREADY;
    logic [30:0] M_AWADDR; logic M_AWVALID, M_AWREADY;
    logic [63:0] M_WDATA;  logic [7:0] M_WSTRB; logic M_WVALID, M_WREADY;
    logic [1:0]  M_BRESP;  logic M_BVALID, M_BREADY;
    logic [30:0] M_ARADDR; logic M_ARVALID, M_ARREADY;
    logic [63:0] M_RDATA;  logic [1:0] M_RRESP; logic M_RVALID, M_RREADY;

    axi4_to_lite_bridge dut (
        .CLK(CLK), .RST(RST),
        .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE),
        .S_AWBURST(S_AWBURST), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID),
        .S_WREADY(S_WREADY),
        .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
        .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
        .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    int checks = 0;
    int errors = 0;

    // expected downstream traffic and upstream responses
    logic [30:0] exp_aw_q[$];
    logic [71:0] exp_w_q[$];
    logic [30:0] exp_ar_q[$];
    logic [5:0]  exp_b_q[$];
    r_exp_t      exp_r_q[$];
    // what the slave model will answer
    logic [1:0]  slave_bresp_q[$];
    logic [65:0] slave_r_q[$];
    // observation logs for directed checks
    logic [30:0] aw_log[$];
    logic [30:0] ar_log[$];
    logic [3:0]  last_bid;
    logic [1:0]  last_bresp;
    int          aw_count = 0;
    int          r_beats  = 0;
    logic        stall = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no/unexpected event expected a matching event", name);
    endtask

    // Address of beat i computed from the burst rules directly (wrap as a modular offset).
    function automatic logic [30:0] exp_addr(input logic [30:0] start, input int len,
                                             input int size, input int burst, input int i);
        longint inc, wsize, off, base;
        inc = longint'(1) << ((size > 3) ? 3 : size);
        case (burst)
            0: return start;
            2: begin
                wsize = longint'(len + 1) << size;
                off   = longint'(start) % wsize;
                base  = longint'(start) - off;
                return 31'(base + (off + longint'(i) * inc) % wsize);
            end
            default: return 31'((longint'(start) + longint'(i) * inc) % (longint'(1) << 31));
        endcase
    endfunction

    // Downstream AXI-lite slave with random readiness and scripted responses.
    initial begin
        logic hs_aw, hs_w, hs_b, hs_ar, hs_r;
        int aw_pend, w_pend, ar_pend;
        logic [65:0] rd;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b0; M_BRESP = '0;
        M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0;   M_RRESP = '0;
        forever begin
            @(negedge CLK);
            hs_aw = M_AWVALID && M_AWREADY;
            hs_w  = M_WVALID && M_WREADY;
            hs_b  = M_BVALID && M_BREADY;
            hs_ar = M_ARVALID && M_ARREADY;
            hs_r  = M_RVALID && M_RREADY;
            @(posedge CLK);
            #1;
            if (RST) begin
                aw_pend = 0; w_pend = 0; ar_pend = 0;
                M_BVALID = 1'b0; M_RVALID = 1'b0;
                M_AWREADY = 1'b0; M_WREADY = 1'b0; M_ARREADY = 1'b0;
                continue;
            end
            if (hs_aw) aw_pend++;
            if (hs_w)  w_pend++;
            if (hs_ar) ar_pend++;
            if (hs_b)  M_BVALID = 1'b0;
            if (hs_r)  M_RVALID = 1'b0;
            if (!M_BVALID && aw_pend > 0 && w_pend > 0 && slave_bresp_q.size() > 0
                && $urandom_range(0, 2) != 0) begin
                M_BRESP  = slave_bresp_q.pop_front();
                M_BVALID = 1'b1;
                aw_pend--;
                w_pend--;
            end
            if (!M_RVALID && ar_pend > 0 && slave_r_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                rd = slave_r_q.pop_front();
                M_RDATA  = rd[65:2];
                M_RRESP  = rd[1:0];
                M_RVALID = 1'b1;
                ar_pend--;
            end
            M_AWREADY = !stall && ($urandom_range(0, 3) != 0);
            M_WREADY  = !stall && ($urandom_range(0, 3) != 0);
            M_ARREADY = !stall && ($urandom_range(0, 3) != 0);
        end
    end

    // Upstream response backpressure.
    initial begin
        S_BREADY = 1'b0;
        S_RREADY = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            S_BREADY = ($urandom_range(0, 3) != 0);
            S_RREADY = ($urandom_range(0, 3) != 0);
        end
    end

    // Compare process: every handshake against the model, plus payload stability under VALID.
    initial begin
        logic        aw_hold, w_hold, ar_hold;
        logic [30:0] aw_prev, ar_prev;
        logic [71:0] w_prev;
        r_exp_t      e;
        logic [5:0]  eb;
        aw_hold = 1'b0; w_hold = 1'b0; ar_hold = 1'b0;
        aw_prev = '0;   ar_prev = '0;  w_prev = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                aw_hold = 1'b0; w_hold = 1'b0; ar_hold = 1'b0;
                continue;
            end
            if (M_AWVALID && aw_hold) check("m_awaddr_stable", 64'(M_AWADDR), 64'(aw_prev));
            if (M_WVALID && w_hold)   check("m_wdata_stable", 64'({M_WDATA, M_WSTRB} ^ w_prev), 64'd0);
            if (M_ARVALID && ar_hold) check("m_araddr_stable", 64'(M_ARADDR), 64'(ar_prev));
            aw_hold = M_AWVALID && !M_AWREADY; aw_prev = M_AWADDR;
            w_hold  = M_WVALID && !M_WREADY;   w_prev  = {M_WDATA, M_WSTRB};
            ar_hold = M_ARVALID && !M_ARREADY; ar_prev = M_ARADDR;

            if (M_AWVALID && M_AWREADY) begin
                aw_count++;
                aw_log.push_back(M_AWADDR);
                if (exp_aw_q.size() == 0) fail_now("m_aw_extra");
                else check("m_awaddr", 64'(M_AWADDR), 64'(exp_aw_q.pop_front()));
            end
            if (M_WVALID && M_WREADY) begin
                if (exp_w_q.size() == 0) fail_now("m_w_extra");
                else begin
                    w_prev = exp_w_q.pop_front();
                    check("m_wdata", M_WDATA, w_prev[71:8]);
                    check("m_wstrb", 64'(M_WSTRB), 64'(w_prev[7:0]));
                    w_prev = {M_WDATA, M_WSTRB};
                end
            end
            if (M_ARVALID && M_ARREADY) begin
                ar_log.push_back(M_ARADDR);
                if (exp_ar_q.size() == 0) fail_now("m_ar_extra");
                else check("m_araddr", 64'(M_ARADDR), 64'(exp_ar_q.pop_front()));
            end
            if (S_BVALID && S_BREADY) begin
                last_bid   = S_BID;
                last_bresp = S_BRESP;
                if (exp_b_q.size() == 0) fail_now("s_b_extra");
                else begin
                    eb = exp_b_q.pop_front();
                    check("s_bid", 64'(S_BID), 64'(eb[5:2]));
                    check("s_bresp", 64'(S_BRESP), 64'(eb[1:0]));
                end
            end
            if (S_RVALID && S_RREADY) begin
                r_beats++;
                if (exp_r_q.size() == 0) fail_now("s_r_extra");
                else begin
                    e = exp_r_q.pop_front();
                    check("s_rid", 64'(S_RID), 64'(e.id));
                    check("s_rdata", S_RDATA, e.data);
                    check("s_rresp", 64'(S_RRESP), 64'(e.resp));
                    check("s_rlast", 64'(S_RLAST), 64'(e.last));
                end
            end
        end
    end

    // which: 0 = AW, 1 = AR, 2 = W. Returns just after the handshake edge.
    task automatic wait_hs(input int which, input string name);
        int  t;
        logic rdy;
        t = 0;
        do begin
            @(negedge CLK);
            t++;
            case (which)
                0:       rdy = S_AWREADY;
                1:       rdy = S_ARREADY;
                default: rdy = S_WREADY;
            endcase
        end while (!rdy && t < 500);
        if (!rdy) fail_now(name);
        @(posedge CLK);
        #1;
    endtask

    // which: 0 = write response queue, 1 = read data queue.
    task automatic wait_drain(input int which, input string name);
        int t;
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (((which == 0) ? exp_b_q.size() : exp_r_q.size()) != 0 && t < 3000);
        if (((which == 0) ? exp_b_q.size() : exp_r_q.size()) != 0) fail_now(name);
        @(posedge CLK);
        #1;
    endtask

    // resp_sel: -2 all OKAY, -1 random per beat, k>=0 SLVERR on beat k only.
    // bad_beat: beat whose WLAST is inverted, -1 for none.
    task automatic write_burst(input int id, input logic [30:0] addr, input int len, input int size,
                               input int burst, input int bad_beat, input int resp_sel,
                               input logic [63:0] seed, input logic [7:0] strb);
        logic [1:0] worst, r;
        worst = 2'd0;
        for (int i = 0; i <= len; i++) begin
            exp_aw_q.push_back(exp_addr(addr, len, size, burst, i));
            exp_w_q.push_back({seed + 64'(i), strb});
            if (resp_sel == -1) r = 2'($urandom_range(0, 3));
            else r = (resp_sel == i) ? 2'd2 : 2'd0;
            slave_bresp_q.push_back(r);
            if (r > worst) worst = r;
        end
        if (bad_beat >= 0 && worst < 2'd2) worst = 2'd2;
        exp_b_q.push_back({4'(id), worst});
        S_AWID = 4'(id); S_AWADDR = addr; S_AWLEN = 8'(len);
        S_AWSIZE = 3'(size); S_AWBURST = 2'(burst); S_AWVALID = 1'b1;
        wait_hs(0, "aw_handshake_timeout");
        S_AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
            end
            S_WDATA = seed + 64'(i);
            S_WSTRB = strb;
            S_WLAST = (i == len) ^ (i == bad_beat);
            S_WVALID = 1'b1;
            wait_hs(2, "w_handshake_timeout");
            S_WVALID = 1'b0;
        end
        wait_drain(0, "b_response_timeout");
    endtask

    task automatic plan_read(input int id, input logic [30:0] addr, input int len, input int size,
                             input int burst);
        logic [63:0] d;
        logic [1:0]  r;
        r_exp_t      e;
        for (int i = 0; i <= len; i++) begin
            d = {$urandom, $urandom};
            r = 2'($urandom_range(0, 3));
            exp_ar_q.push_back(exp_addr(addr, len, size, burst, i));
            slave_r_q.push_back({d, r});
            e.id = 4'(id); e.data = d; e.resp = r; e.last = (i == len);
            exp_r_q.push_back(e);
        end
        S_ARID = 4'(id); S_ARADDR = addr; S_ARLEN = 8'(len);
        S_ARSIZE = 3'(size); S_ARBURST = 2'(burst);
    endtask

    task automatic read_burst(input int id, input logic [30:0] addr, input int len, input int size,
                              input int burst);
        plan_read(id, addr, len, size, burst);
        S_ARVALID = 1'b1;
        wait_hs(1, "ar_handshake_timeout");
        S_ARVALID = 1'b0;
        wait_drain(1, "r_data_timeout");
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_s_awready"}, 64'(S_AWREADY), 64'd1);
        check({tag, "_s_arready"}, 64'(S_ARREADY), 64'd1);
        check({tag, "_valids"}, 64'({S_BVALID, S_RVALID, M_AWVALID, M_WVALID, M_ARVALID}), 64'd0);
        check({tag, "_readies"}, 64'({S_WREADY, M_BREADY, M_RREADY}), 64'd0);
        check({tag, "_rdata"}, S_RDATA, 64'd0);
        check({tag, "_ids_resps"}, 64'({S_BID, S_BRESP, S_RID, S_RRESP}), 64'd0);
    endtask

    task automatic clear_queues();
        exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
        exp_b_q.delete();  exp_r_q.delete();
        slave_bresp_q.delete(); slave_r_q.delete();
    endtask

    initial begin
        int base, t, len, size, burst, bad;
        RST = 1'b1;
        S_AWID = '0; S_AWADDR = '0; S_AWLEN = '0; S_AWSIZE = '0; S_AWBURST = '0; S_AWVALID = 1'b0;
        S_WDATA = '0; S_WSTRB = '0; S_WLAST = 1'b0; S_WVALID = 1'b0;
        S_ARID = '0; S_ARADDR = '0; S_ARLEN = '0; S_ARSIZE = '0; S_ARBURST = '0; S_ARVALID = 1'b0;
        last_bid = '0; last_bresp = '0;

        // model pins
        check("model_wrap_beat1", 64'(exp_addr(31'h38, 3, 3, 2, 1)), 64'h20);
        check("model_incr_beat3", 64'(exp_addr(31'h2000, 3, 3, 1, 3)), 64'h2018);
        check("model_incr_mod31", 64'(exp_addr(31'h7FFF_FFFC, 1, 2, 1, 1)), 64'h0);
        check("model_fixed", 64'(exp_addr(31'h1234, 5, 3, 0, 4)), 64'h1234);

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check_idle_outputs("reset");
        @(posedge CLK);
        #1;

        // single-beat write
        aw_log.delete(); base = aw_count;
        write_burst(5, 31'h1000, 0, 3, 1, -1, -2, 64'hDEADBEEF_00000001, 8'hFF);
        check("single_aw_count", 64'(aw_count - base), 64'd1);
        check("single_awaddr", 64'(aw_log[0]), 64'h1000);
        check("single_bresp", 64'(last_bresp), 64'd0);
        check("single_bid", 64'(last_bid), 64'd5);

        // INCR read
        ar_log.delete();
        read_burst(2, 31'h2000, 3, 3, 1);
        check("incr_ar_count", 64'(ar_log.size()), 64'd4);
        if (ar_log.size() == 4) begin
            check("incr_ar0", 64'(ar_log[0]), 64'h2000);
            check("incr_ar1", 64'(ar_log[1]), 64'h2008);
            check("incr_ar2", 64'(ar_log[2]), 64'h2010);
            check("incr_ar3", 64'(ar_log[3]), 64'h2018);
        end

        // WRAP read
        ar_log.delete();
        read_burst(7, 31'h38, 3, 3, 2);
        check("wrap_ar_count", 64'(ar_log.size()), 64'd4);
        if (ar_log.size() == 4) begin
            check("wrap_ar0", 64'(ar_log[0]), 64'h38);
            check("wrap_ar1", 64'(ar_log[1]), 64'h20);
            check("wrap_ar2", 64'(ar_log[2]), 64'h28);
            check("wrap_ar3", 64'(ar_log[3]), 64'h30);
        end

        // SLVERR on the middle beat only
        base = aw_count;
        write_burst(1, 31'h400, 2, 3, 1, -1, 1, 64'h55, 8'h0F);
        check("slverr_aw_count", 64'(aw_count - base), 64'd3);
        check("slverr_bresp", 64'(last_bresp), 64'd2);

        // early WLAST
        base = aw_count;
        write_burst(3, 31'h800, 1, 3, 1, 0, -2, 64'h99, 8'hFF);
        check("early_wlast_aw_count", 64'(aw_count - base), 64'd2);
        check("early_wlast_bresp", 64'(last_bresp), 64'd2);

        // simultaneous AW/AR with downstream stalled for 5 cycles
        stall = 1'b1;
        fork
            write_burst(9, 31'h3000, 1, 3, 1, -1, -2, 64'h1111, 8'hF0);
            read_burst(10, 31'h5000, 1, 3, 1);
            begin
                repeat (5) @(posedge CLK);
                #1;
                stall = 1'b0;
            end
        join
        check("concurrent_bresp", 64'(last_bresp), 64'd0);
        check("concurrent_bid", 64'(last_bid), 64'd9);

        // randomized concurrent bursts
        for (int n = 0; n < 25; n++) begin
            fork
                begin
                    int wl, ws, wb, wbad;
                    wb = $urandom_range(0, 3);
                    if (wb == 2) begin
                        wl = (2 << $urandom_range(0, 2)) - 1;
                        ws = $urandom_range(0, 3);
                    end else begin
                        wl = $urandom_range(0, 7);
                        ws = $urandom_range(0, 7);
                    end
                    wbad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, wl) : -1;
                    write_burst($urandom_range(0, 15), 31'($urandom), wl, ws, wb, wbad, -1,
                                {$urandom, $urandom}, 8'($urandom));
                end
                begin
                    burst = $urandom_range(0, 3);
                    if (burst == 2) begin
                        len  = (2 << $urandom_range(0, 2)) - 1;
                        size = $urandom_range(0, 3);
                    end else begin
                        len  = $urandom_range(0, 7);
                        size = $urandom_range(0, 7);
                    end
                    read_burst($urandom_range(0, 15), 31'($urandom), len, size, burst);
                end
            join
        end

        // reset in the middle of a read burst
        r_beats = 0;
        plan_read(3, 31'h4000, 3, 3, 1);
        S_ARVALID = 1'b1;
        wait_hs(1, "rst_ar_handshake_timeout");
        S_ARVALID = 1'b0;
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (!(r_beats >= 1 && M_ARVALID) && t < 500);
        if (!(r_beats >= 1 && M_ARVALID)) fail_now("rst_mid_read_setup_timeout");
        #2;
        RST = 1'b1;
        #1;
        check("rst_async_s_rvalid", 64'(S_RVALID), 64'd0);
        check("rst_async_m_arvalid", 64'(M_ARVALID), 64'd0);
        clear_queues();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        @(posedge CLK);
        #1;
        ar_log.delete();
        read_burst(6, 31'h100, 0, 3, 1);
        check("post_rst_ar_count", 64'(ar_log.size()), 64'd1);
        if (ar_log.size() == 1) check("post_rst_araddr", 64'(ar_log[0]), 64'h100);

        // nothing left outstanding
        check("leftover_aw", 64'(exp_aw_q.size()), 64'd0);
        check("leftover_w", 64'(exp_w_q.size()), 64'd0);
        check("leftover_ar", 64'(exp_ar_q.size()), 64'd0);
        check("leftover_b", 64'(exp_b_q.size()), 64'd0);
        check("leftover_r", 64'(exp_r_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi4_to_lite_bridge.md
AXI4_TO_LITE_BRIDGE -- requirements
Module: axi4_to_lite_bridge

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have these ports:
- CLK  in  1  sole clock; all logic on rising edge
- RST  in  1  reset; asynchronous assert, active-high
- S_AW{ID,ADDR,LEN,SIZE,BURST,VALID}  in  4,31,8,3,2,1  AXI4 write-address from the core MMIO port
- S_AWREADY  out  1
- S_W{DATA,STRB,LAST,VALID}  in  64,8,1,1  write data
- S_WREADY  out  1
- S_B{ID,RESP,VALID}  out  4,2,1  write response
- S_BREADY  in  1
- S_AR{ID,ADDR,LEN,SIZE,BURST,VALID}  in  4,31,8,3,2,1  read address
- S_ARREADY  out  1
- S_R{ID,DATA,RESP,LAST,VALID}  out  4,64,2,1,1  read data
- S_RREADY  in  1
- M_AW{ADDR,VALID}/M_AWREADY  out,out/in  31,1/1  AXI-lite write address to the MMIO debugger slave
- M_W{DATA,STRB,VALID}/M_WREADY  out/in  64,8,1/1
- M_B{RESP,VALID}/M_BREADY  in/out  2,1/1
- M_AR{ADDR,VALID}/M_ARREADY  out/in  31,1/1
- M_R{DATA,RESP,VALID}/M_RREADY  in/out  64,2,1/1
REQ-003 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-004 Write and read engines SHALL operate independently and concurrently; each handles one AXI4 burst at a time.
REQ-005 Write FSM SHALL have states W_IDLE, W_DATA, W_ISSUE, W_RESP and W_BRESP.
- W_IDLE: S_AWREADY=1; on handshake, latch id/addr/len/size/burst, clear beat count and resp accumulator, go to W_DATA.
- W_DATA: S_WREADY=1; on handshake, latch data/strb, go to W_ISSUE.
- W_ISSUE: M_AWVALID and M_WVALID both rise in the same cycle; each drops independently on its own handshake; when both are done, go to W_RESP.
- W_RESP: M_BREADY=1; on M_BVALID, merge resp; if beat==len go to W_BRESP, else advance addr, increment beat, go to W_DATA.
- W_BRESP: S_BVALID=1 with latched id and merged resp; on S_BREADY go to W_IDLE.
REQ-006 Read FSM SHALL have states R_IDLE, R_ISSUE, R_WAIT and R_DATA.
- R_IDLE: S_ARREADY=1; on handshake, latch fields and go to R_ISSUE.
- R_ISSUE: M_ARVALID=1; on M_ARREADY go to R_WAIT.
- R_WAIT: M_RREADY=1; on M_RVALID, register data/resp and go to R_DATA.
- R_DATA: S_RVALID=1, S_RID=latched id, S_RLAST=(beat==len); on S_RREADY, go to R_IDLE if last, else advance addr, increment beat, go to R_ISSUE.
REQ-007 Beat count SHALL be 8 bits; a burst SHALL consist of exactly LEN+1 downstream transactions.
REQ-008 The increment SHALL be inc=1<<min(SIZE,3).
- FIXED (00): addr unchanged.
- INCR (01) and reserved (11): addr+inc, modulo 2^31.
- WRAP (10): mask=((LEN+1)<<size)-1; next=(addr & ~mask) | ((addr+inc) & mask).
REQ-009 Write resp merge SHALL keep the numerically largest value seen (OKAY 0 < EXOKAY 1 < SLVERR 2 < DECERR 3).
REQ-010 If S_WLAST is inconsistent with beat==len on any beat, the burst SHALL still run LEN+1 beats, and the final BRESP SHALL be at least SLVERR (2).
REQ-011 Read resp SHALL pass through per beat unchanged.
REQ-012 Minimum latency: write single beat, S_W handshake to S_BVALID = 3 cycles with zero-wait slave; read single beat, S_AR handshake to S_RVALID = 3 cycles.
REQ-013 All outputs SHALL be driven from registers (or state decode); there is no combinational path from M_* inputs to S_* outputs.
REQ-014 M_AWADDR, M_WDATA, M_WSTRB and M_ARADDR SHALL remain stable while the corresponding VALID is high.

Reset
REQ-015 On RST, both FSMs SHALL enter *_IDLE asynchronously.
REQ-016 During and immediately after reset, all VALID outputs SHALL be 0, S_AWREADY/S_ARREADY SHALL be 1 after deassert, other READY outputs SHALL be 0, and data/id/resp registers SHALL be 0.
REQ-017 Reset mid-burst SHALL abandon the burst with no further downstream or upstream transfers.

Verification
REQ-018 Single write: AW addr 0x1000, LEN 0, SIZE 3, INCR; W 0xDEADBEEF_00000001, strb 0xFF, last -> one M_AW 0x1000 + M_W beat; S_BRESP 0, S_BID echoed.
REQ-019 INCR read: AR 0x2000, LEN 3, SIZE 3 -> M_ARADDR 0x2000, 0x2008, 0x2010, 0x2018; four S_R beats with S_RLAST on the 4th only.
REQ-020 WRAP read: AR 0x0038, LEN 3, SIZE 3 -> addresses 0x38, 0x20, 0x28, 0x30.
REQ-021 Write burst LEN 2 where the slave returns SLVERR on beat 1 only -> single S_BRESP=2 after the 3rd M_B.
REQ-022 Write LEN 1 with WLAST on beat 0 -> 2 downstream writes; S_BRESP=2.
REQ-023 Concurrent AW and AR in the same cycle with downstream backpressure (READY held low 5 cycles) -> both complete; RST asserted mid-read -> S_RVALID and M_ARVALID 0 at once; next AR is accepted normally.
